sd_list_formatter: RTL

Text formatter between `sd_file_list_reader` and the UART transmitter. It captures each directory entry strobed by the reader and emits it as an ASCII line: a zero-padded 4-digit decimal file number, one space, the file name, then CR LF. When the reader signals completion it appends a single `END` line. Bytes are delivered over a valid/ready byte handshake.

---
 rtl/sd_list_formatter_if.sv | 10 +
 rtl/sd_list_formatter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sd_list_formatter_if.sv
// Byte stream from the list formatter to the UART transmitter.
// The master holds tx_data/tx_valid until the slave raises tx_ready.
interface sd_list_formatter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sd_list_formatter.sv
// Formats directory entries as "NNNN name\r\n" ASCII lines and ends the listing with "END\r\n".
//
// state | meaning
// IDLE  | waiting for an entry strobe or a pending done
// CONV  | binary-to-BCD, one subtraction or digit check per cycle
// NUM   | emitting the four decimal digits, most significant first
// SP    | emitting the separating space
// NAME  | emitting name bytes 0..len-1
// CR    | emitting carriage return
// LF    | emitting line feed, then waiting for it to be accepted
// EMSG  | emitting "END" ahead of the final CR/LF
// HALT  | listing finished; only reset leaves
module sd_list_formatter #(
  parameter int NAME_MAX = 52
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 list_en,
  input  logic [12:0]          list_file_num,
  input  logic [7:0]           list_name [0:NAME_MAX-1],
  input  logic [7:0]           list_namelen,
  input  logic                 done,
  sd_list_formatter_if.master  tx,
  output logic                 busy,
  output logic [7:0]           drop_cnt,
  output logic                 end_sent
);

  localparam int         IW         = $clog2(NAME_MAX);
  localparam logic [7:0] NAME_MAX_B = 8'(NAME_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_CONV, S_NUM, S_SP, S_NAME, S_CR, S_LF, S_EMSG, S_HALT
  } state_t;

  state_t          state;
  logic [12:0]     val;
  logic [3:0][3:0] digits;
  logic [1:0]      pos;
  logic [1:0]      didx;
  logic [IW-1:0]   idx;
  logic [7:0]      len;
  logic [7:0]      name_buf [0:NAME_MAX-1];
  logic [1:0]      emsg_idx;
  logic            lf_loaded;
  logic            in_end;
  logic            done_seen;

  logic [12:0]     weight;
  logic [7:0]      cur_byte;
  logic            emit;
  logic            tx_accept;
  logic            slot_free;

  assign tx_accept = tx.tx_valid && tx.tx_ready;
  assign slot_free = !tx.tx_valid || tx.tx_ready;

  always_comb begin
    weight = 13'd10;
    case (pos)
      2'd3:    weight = 13'd1000;
      2'd2:    weight = 13'd100;
      default: weight = 13'd10;
    endcase
  end

  always_comb begin
    cur_byte = 8'h00;
    emit     = 1'b0;
    case (state)
      S_NUM:  begin emit = 1'b1; cur_byte = 8'h30 + {4'h0, digits[didx]}; end
      S_SP:   begin emit = 1'b1; cur_byte = 8'h20; end
      S_NAME: begin emit = 1'b1; cur_byte = name_buf[idx]; end
      S_CR:   begin emit = 1'b1; cur_byte = 8'h0D; end
      S_LF:   begin emit = !lf_loaded; cur_byte = 8'h0A; end
      S_EMSG: begin
        emit = 1'b1;
        case (emsg_idx)
          2'd0:    cur_byte = 8'h45;
          2'd1:    cur_byte = 8'h4E;
          default: cur_byte = 8'h44;
        endcase
      end
      default: begin emit = 1'b0; cur_byte = 8'h00; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tx.tx_valid <= 1'b0;
      tx.tx_data  <= 8'h00;
      busy        <= 1'b0;
      drop_cnt    <= 8'h00;
      end_sent    <= 1'b0;
      done_seen   <= 1'b0;
      val         <= '0;
      digits      <= '0;
      pos         <= 2'd3;
      didx        <= 2'd3;
      idx         <= '0;
      len         <= 8'h00;
      emsg_idx    <= 2'd0;
      lf_loaded   <= 1'b0;
      in_end      <= 1'b0;
    end else begin
      if (done) done_seen <= 1'b1;
      if (list_en && busy && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      if (tx_accept) tx.tx_valid <= 1'b0;
      if (emit && slot_free) begin
        tx.tx_valid <= 1'b1;
        tx.tx_data  <= cur_byte;
      end

      case (state)
        S_IDLE: begin
          if (list_en) begin
            val      <= list_file_num;
            name_buf <= list_name;
            len      <= (list_namelen > NAME_MAX_B) ? NAME_MAX_B : list_namelen;
            digits   <= '0;
            pos      <= 2'd3;
            in_end   <= 1'b0;
            busy     <= 1'b1;
            state    <= S_CONV;
          end else if ((done || done_seen) && !end_sent) begin
            emsg_idx <= 2'd0;
            in_end   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_EMSG;
          end
        end
        S_CONV: begin
          if (val >= weight) begin
            val         <= val - weight;
            digits[pos] <= digits[pos] + 4'd1;
          end else if (pos == 2'd1) begin
            digits[0] <= val[3:0];
            didx      <= 2'd3;
            state     <= S_NUM;
          end else begin
            pos <= pos - 2'd1;
          end
        end
        S_NUM: if (slot_free) begin
          didx <= didx - 2'd1;
          if (didx == 2'd0) state <= S_SP;
        end
        S_SP: if (slot_free) begin
          idx   <= '0;
          state <= (len == 8'h00) ? S_CR : S_NAME;
        end
        S_NAME: if (slot_free) begin
          idx <= idx + 1'b1;
          if (8'(idx) == len - 8'd1) state <= S_CR;
        end
        S_CR: if (slot_free) begin
          lf_loaded <= 1'b0;
          state     <= S_LF;
        end
        // The LF must be accepted before leaving so busy covers the whole line.
        S_LF: begin
          if (!lf_loaded) begin
            if (slot_free) lf_loaded <= 1'b1;
          end else if (tx_accept) begin
            lf_loaded <= 1'b0;
            if (in_end) begin
              end_sent <= 1'b1;
              state    <= S_HALT;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        S_EMSG: if (slot_free) begin
          emsg_idx <= emsg_idx + 2'd1;
          if (emsg_idx == 2'd2) state <= S_CR;
        end
        S_HALT: state <= S_HALT;
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
